// File: rtl/mem_port_arbiter_if.sv
// Unified memory port bus: valid/ready request channel plus read-data return.
// The master modport is the arbiter side; the slave modport is the memory side.
interface mem_port_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with data
// priority, byte/word formatting, a one-cycle done pulse and a wait watchdog.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_addr_mode,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        err,
  output logic        stall,
  mem_port_arbiter_if.master mem
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t        r_state,     w_state;
  logic          r_mem_valid, w_mem_valid;
  logic          r_mem_we,    w_mem_we;
  logic [31:0]   r_mem_addr,  w_mem_addr;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata;
  logic [BW-1:0] r_mem_be,    w_mem_be;
  logic          r_byte,      w_byte;
  logic [1:0]    r_lane,      w_lane;
  logic [CW-1:0] r_wait,      w_wait;
  logic [DW-1:0] r_if_rdata,  w_if_rdata;
  logic [DW-1:0] r_d_rdata,   w_d_rdata;
  logic          r_if_done,   w_if_done;
  logic          r_d_done,    w_d_done;
  logic          r_err,       w_err;
  logic [DW-1:0] w_load_data;
  logic          w_unused;

  // Fetch addresses are word aligned by construction; the low bits carry no meaning.
  assign w_unused = ^if_addr[1:0];

  // Load result: word as-is, byte as zero-extended lane selected at grant time.
  always_comb begin
    w_load_data = mem.mem_rdata;
    if (r_byte) begin
      case (r_lane)
        2'd0:    w_load_data = {24'd0, mem.mem_rdata[7:0]};
        2'd1:    w_load_data = {24'd0, mem.mem_rdata[15:8]};
        2'd2:    w_load_data = {24'd0, mem.mem_rdata[23:16]};
        default: w_load_data = {24'd0, mem.mem_rdata[31:24]};
      endcase
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_mem_valid = r_mem_valid;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_be    = r_mem_be;
    w_byte      = r_byte;
    w_lane      = r_lane;
    w_wait      = r_wait;
    w_if_rdata  = r_if_rdata;
    w_d_rdata   = r_d_rdata;
    w_if_done   = 1'b0;
    w_d_done    = 1'b0;
    w_err       = 1'b0;

    case (r_state)
      IDLE: begin
        if (d_req) begin
          w_state     = BUSY_D;
          w_mem_valid = 1'b1;
          w_mem_we    = d_we;
          w_mem_addr  = {d_addr[31:2], 2'b00};
          w_byte      = d_addr_mode;
          w_lane      = d_addr[1:0];
          w_wait      = '0;
          w_mem_be    = d_addr_mode ? BW'(4'b0001 << d_addr[1:0]) : {BW{1'b1}};
          if (!d_we)
            w_mem_wdata = '0;
          else if (d_addr_mode)
            w_mem_wdata = {4{d_wdata[7:0]}};
          else
            w_mem_wdata = d_wdata;
        end else if (if_req) begin
          w_state     = BUSY_IF;
          w_mem_valid = 1'b1;
          w_mem_we    = 1'b0;
          w_mem_addr  = {if_addr[31:2], 2'b00};
          w_mem_be    = {BW{1'b1}};
          w_mem_wdata = '0;
          w_byte      = 1'b0;
          w_lane      = 2'd0;
          w_wait      = '0;
        end
      end

      BUSY_IF, BUSY_D: begin
        // A ready in the final allowed cycle still completes normally.
        if (mem.mem_ready || (r_wait == CW'(MAX_WAIT))) begin
          w_state     = RESP;
          w_mem_valid = 1'b0;
          w_mem_we    = 1'b0;
          w_err       = ~mem.mem_ready;
          if (r_state == BUSY_D) begin
            w_d_done  = 1'b1;
            w_d_rdata = mem.mem_ready ? w_load_data : '0;
          end else begin
            w_if_done  = 1'b1;
            w_if_rdata = mem.mem_ready ? mem.mem_rdata : '0;
          end
        end else begin
          w_wait = r_wait + CW'(1);
        end
      end

      RESP: begin
        w_state = IDLE;
      end

      default: begin
        w_state     = IDLE;
        w_mem_valid = 1'b0;
        w_mem_we    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_byte      <= 1'b0;
      r_lane      <= 2'd0;
      r_wait      <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_mem_valid <= w_mem_valid;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_be    <= w_mem_be;
      r_byte      <= w_byte;
      r_lane      <= w_lane;
      r_wait      <= w_wait;
      r_if_rdata  <= w_if_rdata;
      r_d_rdata   <= w_d_rdata;
      r_if_done   <= w_if_done;
      r_d_done    <= w_d_done;
      r_err       <= w_err;
    end
  end

  assign mem.mem_valid = r_mem_valid;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign mem.mem_be    = r_mem_be;
  assign if_rdata      = r_if_rdata;
  assign if_done       = r_if_done;
  assign d_rdata       = r_d_rdata;
  assign d_done        = r_d_done;
  assign err           = r_err;

  // Freezes PC and register write while either side still waits for its done.
  assign stall = (if_req & ~r_if_done) | (d_req & ~r_d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small memory responder with a
// programmable wait count and hand-computed expectations per access.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic        d_addr_mode;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        err;
  logic        stall;

  mem_port_arbiter_if mem ();

  mem_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_done     (if_done),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr_mode (d_addr_mode),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_done      (d_done),
    .err         (err),
    .stall       (stall),
    .mem         (mem)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wait_states = 0;
  logic [31:0] rdata_val = 32'h0;
  int          rsp_cnt = 0;
  int          n_grants = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic [31:0] acc_wdata = 32'h0;
  logic [3:0]  acc_be = 4'h0;
  logic        acc_we = 1'b0;
  int          acc_len = 0;

  // Memory model: answers after wait_states cycles of valid, records the accepted beat.
  always @(negedge clk) begin
    if (mem.mem_valid === 1'b1) begin
      if (!prev_valid) n_grants++;
      prev_valid    = 1'b1;
      mem.mem_ready = (rsp_cnt == wait_states);
      mem.mem_rdata = rdata_val;
      rsp_cnt++;
      if (mem.mem_ready) begin
        acc_addr  = mem.mem_addr;
        acc_wdata = mem.mem_wdata;
        acc_be    = mem.mem_be;
        acc_we    = mem.mem_we;
        acc_len   = rsp_cnt;
      end
    end else begin
      prev_valid    = 1'b0;
      mem.mem_ready = 1'b0;
      mem.mem_rdata = 32'h0;
      rsp_cnt       = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raises one request and waits (bounded) for any done pulse; counts stall cycles.
  task automatic do_access(input logic is_d, input logic we, input logic mode,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int max_cyc, output int lat, output int stall_n);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr_mode = mode; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    #1;
    lat     = 0;
    stall_n = 0;
    while (1) begin
      if (stall) stall_n++;
      if (if_done || d_done) break;
      if (lat >= max_cyc) begin
        check("wait_bound", 32'd0, 32'd1);
        break;
      end
      step();
      lat++;
    end
  endtask

  int lat, sn, g0, d_cyc, if_cyc;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr_mode = 1'b0; d_addr = '0; d_wdata = '0;
    step(); step();
    check("rst_valid", 32'(mem.mem_valid), 32'd0);
    check("rst_addr",  mem.mem_addr, 32'd0);
    check("rst_be",    32'(mem.mem_be), 32'd0);
    check("rst_done",  32'({if_done, d_done, err}), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b1;
    step();

    // Word fetch, zero wait
    wait_states = 0; rdata_val = 32'hDEAD_BEEF;
    do_access(1'b0, 1'b0, 1'b0, 32'h0000_0106, 32'h0, 20, lat, sn);
    check("fetch_lat",   32'(lat), 32'd2);
    check("fetch_done",  32'(if_done), 32'd1);
    check("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
    check("fetch_stall", 32'(sn), 32'd2);
    check("fetch_addr",  acc_addr, 32'h0000_0104);
    check("fetch_be",    32'(acc_be), 32'hF);
    check("fetch_we",    32'(acc_we), 32'd0);
    check("fetch_err",   32'(err), 32'd0);
    if_req = 1'b0;
    step();
    check("fetch_pulse", 32'(if_done), 32'd0);

    // Byte store to lane 3
    do_access(1'b1, 1'b1, 1'b1, 32'h0000_1003, 32'h1234_56AB, 20, lat, sn);
    check("bst_lat",   32'(lat), 32'd2);
    check("bst_done",  32'(d_done), 32'd1);
    check("bst_addr",  acc_addr, 32'h0000_1000);
    check("bst_be",    32'(acc_be), 32'h8);
    check("bst_wdata", acc_wdata, 32'hABAB_ABAB);
    check("bst_we",    32'(acc_we), 32'd1);
    d_req = 1'b0;
    step();

    // Byte load from lane 1
    rdata_val = 32'h11C3_2244;
    do_access(1'b1, 1'b0, 1'b1, 32'h0000_2001, 32'hFFFF_FFFF, 20, lat, sn);
    check("bld_rdata", d_rdata, 32'h0000_0022);
    check("bld_be",    32'(acc_be), 32'h2);
    check("bld_wdata", acc_wdata, 32'h0);
    check("bld_we",    32'(acc_we), 32'd0);
    d_req = 1'b0;
    step();

    // Byte load from lane 3
    do_access(1'b1, 1'b0, 1'b1, 32'h0000_2003, 32'h0, 20, lat, sn);
    check("bld3_rdata", d_rdata, 32'h0000_0011);
    check("bld3_be",    32'(acc_be), 32'h8);
    d_req = 1'b0;
    step();

    // Word store, one wait state
    wait_states = 1;
    do_access(1'b1, 1'b1, 1'b0, 32'h0000_3008, 32'hCAFE_F00D, 20, lat, sn);
    check("wst_lat",   32'(lat), 32'd3);
    check("wst_wdata", acc_wdata, 32'hCAFE_F00D);
    check("wst_be",    32'(acc_be), 32'hF);
    check("wst_addr",  acc_addr, 32'h0000_3008);
    d_req = 1'b0;
    step();

    // Word load, two wait states
    wait_states = 2; rdata_val = 32'h89AB_CDEF;
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_300C, 32'h0, 20, lat, sn);
    check("wld_lat",   32'(lat), 32'd4);
    check("wld_rdata", d_rdata, 32'h89AB_CDEF);
    d_req = 1'b0;
    step();

    // Contention, three wait states on each access
    wait_states = 3; rdata_val = 32'h5566_7788;
    g0 = n_grants; d_cyc = -1; if_cyc = -1;
    d_req = 1'b1; d_we = 1'b0; d_addr_mode = 1'b0; d_addr = 32'h0000_6000;
    if_req = 1'b1; if_addr = 32'h0000_7000;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (d_done) begin
        d_cyc = c;
        check("cont_d_len",    32'(acc_len), 32'd4);
        check("cont_d_addr",   acc_addr, 32'h0000_6000);
        check("cont_d_rdata",  d_rdata, 32'h5566_7788);
        check("cont_d_grants", 32'(n_grants - g0), 32'd1);
        d_req = 1'b0;
      end
      if (if_done) begin
        if_cyc = c;
        check("cont_if_addr",  acc_addr, 32'h0000_7000);
        check("cont_if_rdata", if_rdata, 32'h5566_7788);
        if_req = 1'b0;
        break;
      end
    end
    check("cont_d_cyc",   32'(d_cyc), 32'd5);
    check("cont_if_cyc",  32'(if_cyc), 32'd11);
    check("cont_grants",  32'(n_grants - g0), 32'd2);
    if_req = 1'b0; d_req = 1'b0;
    step();

    // Timeout with memory never ready
    wait_states = 255; rdata_val = 32'hFFFF_FFFF;
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0, 20, lat, sn);
    check("to_lat",   32'(lat), 32'd6);
    check("to_done",  32'(d_done), 32'd1);
    check("to_err",   32'(err), 32'd1);
    check("to_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    step();
    check("to_err_pulse", 32'(err), 32'd0);

    // Normal access after timeout
    wait_states = 0; rdata_val = 32'h0BAD_F00D;
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_4004, 32'h0, 20, lat, sn);
    check("post_to_lat",   32'(lat), 32'd2);
    check("post_to_err",   32'(err), 32'd0);
    check("post_to_rdata", d_rdata, 32'h0BAD_F00D);
    d_req = 1'b0;
    step();

    // Reset while in BUSY_D, held request re-granted afterwards
    wait_states = 255; rdata_val = 32'h1357_9BDF;
    d_req = 1'b1; d_we = 1'b0; d_addr_mode = 1'b0; d_addr = 32'h0000_5000;
    step();
    check("rm_valid_busy", 32'(mem.mem_valid), 32'd1);
    step();
    rst = 1'b0;
    step();
    check("rm_valid_rst", 32'(mem.mem_valid), 32'd0);
    check("rm_no_done",   32'(d_done), 32'd0);
    rst = 1'b1; wait_states = 0;
    step();
    check("rm_regrant", 32'(mem.mem_valid), 32'd1);
    check("rm_addr",    mem.mem_addr, 32'h0000_5000);
    check("rm_no_done2", 32'(d_done), 32'd0);
    step();
    check("rm_done",  32'(d_done), 32'd1);
    check("rm_rdata", d_rdata, 32'h1357_9BDF);
    d_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
